// File: rtl/snow64_mem_arbiter_pkg.sv
// Shared state/access-type enums and default widths for the Snow64 memory arbiter.
package PkgSnow64MemArbiter;

    localparam int unsigned DefNumChannels = 3;
    localparam int unsigned DefAddrWidth   = 64;
    localparam int unsigned DefDataWidth   = 256;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } State;

    typedef enum logic {
        MemAccTypRead  = 1'b0,
        MemAccTypWrite = 1'b1
    } MemAccessType;

endpackage

// File: rtl/snow64_mem_arbiter_picker.sv
// Combinational winner select: first asserted request at or after i_start, wrapping.
module snow64_mem_arbiter_picker
    import PkgSnow64MemArbiter::*;
#(
    parameter int unsigned NUM_CHANNELS = DefNumChannels,
    localparam int unsigned GRANT_WIDTH = $clog2(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] i_req,
    input  logic [GRANT_WIDTH-1:0]  i_start,
    output logic [GRANT_WIDTH-1:0]  o_winner_c,
    output logic                    o_valid_c
);

    int unsigned w_idx;

    always_comb begin
        o_winner_c = '0;
        o_valid_c  = 1'b0;
        w_idx      = 0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            w_idx = (32'(i_start) + i) % NUM_CHANNELS;
            if (!o_valid_c && i_req[GRANT_WIDTH'(w_idx)]) begin
                o_winner_c = GRANT_WIDTH'(w_idx);
                o_valid_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snow64_mem_arbiter.sv
// N-channel arbiter onto the single Snow64 memory port, one transaction in flight.
// Define SNOW64_MEM_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module snow64_mem_arbiter
    import PkgSnow64MemArbiter::*;
#(
    parameter int unsigned NUM_CHANNELS = DefNumChannels,
    parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    localparam int unsigned GRANT_WIDTH = $clog2(NUM_CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CHANNELS-1:0]          ch_req,
    input  logic [NUM_CHANNELS-1:0]          ch_we,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_wdata,
    output logic [NUM_CHANNELS-1:0]          ch_busy,
    output logic [NUM_CHANNELS-1:0]          ch_done,
    output logic [DATA_WIDTH-1:0]            ch_rdata,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_done,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             status_busy,
    output logic [GRANT_WIDTH-1:0]           grant_id
);

    State                   r_state;
    logic [GRANT_WIDTH-1:0] w_start;
    logic [GRANT_WIDTH-1:0] w_winner;
    logic                   w_valid;
    logic [ADDR_WIDTH-1:0]  w_addr  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]  w_wdata [NUM_CHANNELS];

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
        assign w_addr[gi]  = ch_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[gi] = ch_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef SNOW64_MEM_ARBITER_ROUND_ROBIN_EN
    logic [GRANT_WIDTH-1:0] r_last_grant;

    // Search begins just past the previous winner; reset value makes channel 0 win first.
    assign w_start = (32'(r_last_grant) == NUM_CHANNELS - 1) ? '0
                                                             : r_last_grant + GRANT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_WIDTH'(NUM_CHANNELS - 1);
        end else if (r_state == StIdle && w_valid) begin
            r_last_grant <= w_winner;
        end
    end
`else
    assign w_start = '0;
`endif

    snow64_mem_arbiter_picker #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_picker (
        .i_req      (ch_req),
        .i_start    (w_start),
        .o_winner_c (w_winner),
        .o_valid_c  (w_valid)
    );

    // Requests are sampled only in IDLE, so the DONE cycle never re-grants its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            ch_busy     <= '0;
            ch_done     <= '0;
            ch_rdata    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            status_busy <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_valid) begin
                        mem_we      <= ch_we[w_winner];
                        mem_addr    <= w_addr[w_winner];
                        mem_wdata   <= w_wdata[w_winner];
                        ch_busy     <= NUM_CHANNELS'(1) << w_winner;
                        grant_id    <= w_winner;
                        mem_req     <= 1'b1;
                        status_busy <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    mem_req <= 1'b0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (mem_done) begin
                        if (mem_we == 1'(MemAccTypRead)) begin
                            ch_rdata <= mem_rdata;
                        end
                        ch_done <= ch_busy;
                        ch_busy <= '0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    ch_done     <= '0;
                    status_busy <= 1'b0;
                    r_state     <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snow64_mem_arbiter.sv
// Scoreboard bench for snow64_mem_arbiter: directed transactions, expected issue/done queues.
module tb_snow64_mem_arbiter;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 256;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_we;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_busy;
    logic [NCH-1:0]    ch_done;
    logic [DW-1:0]     ch_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_done;
    logic [DW-1:0]     mem_rdata;
    logic              status_busy;
    logic [1:0]        grant_id;

    logic              resp_done;
    logic              spur_done;
    logic              resp_en;
    int                resp_delay;
    logic [DW-1:0]     resp_rdata;

    assign mem_done  = resp_done | spur_done;
    assign mem_rdata = resp_rdata;

    typedef struct {
        logic [1:0]    gid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } iss_t;

    typedef struct {
        logic [NCH-1:0] done;
        logic [DW-1:0]  rdata;
        logic [AW-1:0]  addr;
        logic           we;
        int             lat;
    } dn_t;

    iss_t q_iss[$];
    dn_t  q_dn[$];
    int   n_cmp        = 0;
    int   n_bad        = 0;
    int   mon_cyc      = 0;
    int   last_req_cyc = 0;

    snow64_mem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_req      (ch_req),
        .ch_we       (ch_we),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_busy     (ch_busy),
        .ch_done     (ch_done),
        .ch_rdata    (ch_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .status_busy (status_busy),
        .grant_id    (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_txn(input logic [1:0] gid, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int lat, input int gap, input bit with_done);
        iss_t a;
        dn_t  b;
        a.gid = gid; a.we = we; a.addr = addr; a.wdata = wdata; a.gap = gap;
        q_iss.push_back(a);
        if (with_done) begin
            b.done = NCH'(1) << gid; b.rdata = rdata; b.addr = addr; b.we = we; b.lat = lat;
            q_dn.push_back(b);
        end
    endtask

    task automatic set_ch(input int i, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        ch_we[i]             = we;
        ch_addr[i*AW +: AW]  = addr;
        ch_wdata[i*DW +: DW] = wdata;
    endtask

    task automatic wait_done(input string nm, input int max_cyc);
        int n;
        n = 0;
        while (ch_done == '0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (ch_done == '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: ch_done timeout got %0h expected nonzero", nm, ch_done);
        end
    endtask

    task automatic wait_req(input string nm, input int max_cyc);
        int n;
        n = 0;
        while (!mem_req && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: mem_req timeout got 0 expected 1", nm);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ch_busy"},     DW'(ch_busy),     DW'(0));
        chk({tag, "_ch_done"},     DW'(ch_done),     DW'(0));
        chk({tag, "_ch_rdata"},    ch_rdata,         DW'(0));
        chk({tag, "_mem_req"},     DW'(mem_req),     DW'(0));
        chk({tag, "_mem_we"},      DW'(mem_we),      DW'(0));
        chk({tag, "_mem_addr"},    DW'(mem_addr),    DW'(0));
        chk({tag, "_mem_wdata"},   mem_wdata,        DW'(0));
        chk({tag, "_status_busy"}, DW'(status_busy), DW'(0));
        chk({tag, "_grant_id"},    DW'(grant_id),    DW'(0));
    endtask

    // Memory model: answers each mem_req after resp_delay cycles.
    initial begin : responder
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && resp_en) begin
                repeat (resp_delay) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    initial begin : monitor
        iss_t a;
        dn_t  b;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (mem_req) begin
                if (q_iss.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_mem_req: got grant_id %0d expected no issue", grant_id);
                end else begin
                    a = q_iss.pop_front();
                    chk("iss_grant_id", DW'(grant_id), DW'(a.gid));
                    chk("iss_mem_we", DW'(mem_we), DW'(a.we));
                    chk("iss_mem_addr", DW'(mem_addr), DW'(a.addr));
                    chk("iss_mem_wdata", mem_wdata, a.wdata);
                    chk("iss_ch_busy", DW'(ch_busy), DW'(3'(1) << a.gid));
                    chk("iss_status_busy", DW'(status_busy), DW'(1));
                    if (a.gap != 0) chk("iss_spacing", DW'(mon_cyc - last_req_cyc), DW'(a.gap));
                    last_req_cyc = mon_cyc;
                end
            end
            if (ch_done != '0) begin
                if (q_dn.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ch_done: got %0b expected 000", ch_done);
                end else begin
                    b = q_dn.pop_front();
                    chk("dn_vector", DW'(ch_done), DW'(b.done));
                    chk("dn_ch_rdata", ch_rdata, b.rdata);
                    chk("dn_mem_addr_held", DW'(mem_addr), DW'(b.addr));
                    chk("dn_mem_we_held", DW'(mem_we), DW'(b.we));
                    chk("dn_ch_busy_clear", DW'(ch_busy), DW'(0));
                    chk("dn_status_busy", DW'(status_busy), DW'(1));
                    chk("dn_latency", DW'(mon_cyc - last_req_cyc), DW'(b.lat));
                end
            end
        end
    end

    initial begin : stimulus
        int order [4];
        rst_n      = 1'b0;
        ch_req     = '0;
        ch_we      = '0;
        ch_addr    = '0;
        ch_wdata   = '0;
        spur_done  = 1'b0;
        resp_en    = 1'b1;
        resp_delay = 1;
        resp_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single read on channel 1.
        resp_delay = 3;
        resp_rdata = {32{8'hAB}};
        set_ch(1, 1'b0, 64'h40, '0);
        exp_txn(2'd1, 1'b0, 64'h40, '0, {32{8'hAB}}, 4, 0, 1'b1);
        ch_req = 3'b010;
        wait_done("rd", 20);
        ch_req = '0;
        @(negedge clk);
        chk("rd_idle_status", DW'(status_busy), DW'(0));

        // Single write on channel 2: ch_rdata must keep the read data.
        resp_rdata = {32{8'hCC}};
        set_ch(2, 1'b1, 64'h80, {32{8'h55}});
        exp_txn(2'd2, 1'b1, 64'h80, {32{8'h55}}, {32{8'hAB}}, 4, 0, 1'b1);
        ch_req = 3'b100;
        wait_done("wr", 20);
        ch_req = '0;
        @(negedge clk);

        // Spurious mem_done while IDLE.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_idle_status", DW'(status_busy), DW'(0));
        chk("spur_idle_busy", DW'(ch_busy), DW'(0));
        @(negedge clk);
        chk("spur_idle_done", DW'(ch_done), DW'(0));

        // Spurious mem_done during ISSUE.
        resp_rdata = {32{8'h33}};
        set_ch(0, 1'b0, 64'h10, '0);
        exp_txn(2'd0, 1'b0, 64'h10, '0, {32{8'h33}}, 4, 0, 1'b1);
        ch_req = 3'b001;
        wait_req("spur_iss", 10);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_iss_status", DW'(status_busy), DW'(1));
        chk("spur_iss_done", DW'(ch_done), DW'(0));
        wait_done("spur_iss", 20);
        ch_req = '0;
        @(negedge clk);

        // Requester inputs change after the grant.
        resp_rdata = {32{8'h77}};
        set_ch(2, 1'b0, 64'h1000, '0);
        exp_txn(2'd2, 1'b0, 64'h1000, '0, {32{8'h77}}, 4, 0, 1'b1);
        ch_req = 3'b100;
        wait_req("hold", 10);
        set_ch(2, 1'b1, 64'hDEAD, {32{8'hEE}});
        @(negedge clk);
        chk("hold_mem_addr", DW'(mem_addr), DW'(64'h1000));
        chk("hold_mem_wdata", mem_wdata, DW'(0));
        wait_done("hold", 20);
        ch_req = '0;
        @(negedge clk);

        // Contention with all requests held, minimum memory latency.
`ifdef SNOW64_MEM_ARBITER_ROUND_ROBIN_EN
        order = '{0, 1, 2, 0};
`else
        order = '{0, 0, 0, 0};
`endif
        resp_delay = 1;
        resp_rdata = {32{8'h99}};
        set_ch(0, 1'b0, 64'h100, '0);
        set_ch(1, 1'b0, 64'h200, '0);
        set_ch(2, 1'b0, 64'h300, '0);
        for (int k = 0; k < 4; k++) begin
            exp_txn(2'(order[k]), 1'b0, 64'((order[k] + 1) * 256), '0, {32{8'h99}}, 2,
                    (k == 0) ? 0 : 4, 1'b1);
        end
        ch_req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_done("cont", 20);
            if (k == 3) ch_req = '0;
            @(negedge clk);
        end

        // Reset in WAIT, then a late mem_done.
        resp_en = 1'b0;
        set_ch(0, 1'b0, 64'h500, '0);
        exp_txn(2'd0, 1'b0, 64'h500, '0, '0, 0, 0, 1'b0);
        ch_req = 3'b001;
        wait_req("rst_wait", 10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        ch_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("late_done_status", DW'(status_busy), DW'(0));
        chk("late_done_ch_done", DW'(ch_done), DW'(0));
        @(negedge clk);

        // Restart after reset: channel 0 wins first.
        resp_en    = 1'b1;
        resp_delay = 2;
        resp_rdata = {32{8'h12}};
        set_ch(0, 1'b0, 64'h600, '0);
        set_ch(2, 1'b0, 64'h700, '0);
        exp_txn(2'd0, 1'b0, 64'h600, '0, {32{8'h12}}, 3, 0, 1'b1);
        ch_req = 3'b101;
        wait_done("restart", 20);
        ch_req = '0;
        repeat (2) @(negedge clk);

        chk("q_iss_drained", DW'(q_iss.size()), DW'(0));
        chk("q_dn_drained", DW'(q_dn.size()), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
